imem_uart_loader: RTL



---
 rtl/imem_uart_loader_pkg.sv | 35 +++
 rtl/imem_uart_loader_uart_rx_8n1.sv | 124 ++++++++++++
 rtl/imem_uart_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared encodings and helpers for the UART instruction-memory loader.
package imem_uart_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_CHK    = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } ld_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_e;

    localparam int HDR_BYTES = 2;
    localparam int CHK_BYTES = 1;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    function automatic logic ld_is_busy(input ld_state_e s);
        case (s)
            LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CHK: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle byte and frame-error strobes.
module uart_rx_8n1
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic             meta_q, sync_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] cnt_dec_s;

    assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
    assign cnt_dec_s  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchroniser, edge history and receiver state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rxd_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Receiver next-state: count to mid-bit, then sample once per bit period
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (prev_q && !sync_q) begin
                    state_d = R_START;
                    cnt_d   = HALF_BIT;
                end else begin
                    state_d = R_IDLE;
                end
            end
            R_START: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_dec_s;
                end else if (sync_q) begin
                    state_d = R_IDLE;
                end else begin
                    state_d = R_DATA;
                    cnt_d   = FULL_BIT;
                    bit_d   = 3'd0;
                end
            end
            R_DATA: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_dec_s;
                end else begin
                    shift_d = {sync_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            R_STOP: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_dec_s;
                end else begin
                    state_d = R_IDLE;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from UART into instruction memory,
// holding the CPU in reset while the load runs.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              start_load,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [7:0]        rx_byte_s;
    logic              rx_valid_s;
    logic              rx_ferr_s;

    ld_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       asm_q, asm_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dina_q, dina_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic              start_ok_s;
    logic [15:0]       len_full_s;
    logic              len_bad_s;
    logic [ADDR_W:0]   words_inc_s;
    logic              last_word_s;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rxd_i       (rxd),
        .byte_o      (rx_byte_s),
        .byte_valid_o(rx_valid_s),
        .frame_err_o (rx_ferr_s)
    );

    assign start_ok_s  = start_load && !ld_is_busy(state_q);
    assign len_full_s  = {len_q[15:8], rx_byte_s};
    assign len_bad_s   = (len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_WORDS);
    assign words_inc_s = words_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word_s = (17'(words_inc_s) == {1'b0, len_q});

    // Loader state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
            len_q   <= 16'h0000;
            asm_q   <= 24'h000000;
            idx_q   <= 2'd0;
            chk_q   <= 8'h00;
            wea_q   <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            dina_q  <= 32'h0000_0000;
            words_q <= {(ADDR_W+1){1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            wea_q   <= wea_d;
            addr_q  <= addr_d;
            dina_q  <= dina_d;
            words_q <= words_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // Loader next-state: header, word assembly with write strobe, checksum verdict
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        asm_d   = asm_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        wea_d   = 1'b0;
        addr_d  = addr_q;
        dina_d  = dina_q;
        words_d = words_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start_ok_s) begin
                    state_d = LD_LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = {(ADDR_W+1){1'b0}};
                    addr_d  = {ADDR_W{1'b0}};
                    chk_d   = 8'h00;
                    idx_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            LD_LEN_HI: begin
                if (rx_ferr_s) begin
                    state_d = LD_ERR;
                    err_d   = 1'b1;
                end else if (rx_valid_s) begin
                    len_d   = {rx_byte_s, 8'h00};
                    state_d = LD_LEN_LO;
                end else begin
                    state_d = state_q;
                end
            end
            LD_LEN_LO: begin
                if (rx_ferr_s) begin
                    state_d = LD_ERR;
                    err_d   = 1'b1;
                end else if (rx_valid_s) begin
                    len_d = len_full_s;
                    if (len_bad_s) begin
                        state_d = LD_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LD_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LD_DATA: begin
                if (rx_ferr_s) begin
                    state_d = LD_ERR;
                    err_d   = 1'b1;
                end else if (wea_q) begin
                    // Address stays on the last word so it never reaches N.
                    words_d = words_inc_s;
                    if (last_word_s) begin
                        state_d = LD_CHK;
                    end else begin
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else if (rx_valid_s) begin
                    chk_d = chk_update(chk_q, rx_byte_s);
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        dina_d = {asm_q, rx_byte_s};
                        wea_d  = 1'b1;
                    end else begin
                        asm_d = {asm_q[15:0], rx_byte_s};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LD_CHK: begin
                if (rx_ferr_s) begin
                    state_d = LD_ERR;
                    err_d   = 1'b1;
                end else if (rx_valid_s) begin
                    if (rx_byte_s == chk_q) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LD_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
        // Rises with the start edge, falls one cycle after leaving the busy states.
        hold_d = ld_is_busy(state_d) || ld_is_busy(state_q);
    end

    assign wea          = wea_q;
    assign addra        = addr_q;
    assign dina         = dina_q;
    assign cpu_hold     = hold_q;
    assign busy         = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
